// File: rtl/mix_core_n.sv
// mix_core_n: gain-weighted, saturating mix of up to NUM_SRC stereo SDRAM tracks
// into a destination region, one 32-bit word per iteration.
module mix_core_n #(
  parameter int NUM_SRC = 4,
  parameter int ADDR_W  = 23,
  parameter int LEN_W   = 16,
  parameter int GAIN_W  = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          mix_start,
  input  logic [(NUM_SRC+1)*ADDR_W-1:0] mix_select,
  input  logic [NUM_SRC-1:0]            mix_enable,
  input  logic [NUM_SRC*GAIN_W-1:0]     mix_gain,
  input  logic [LEN_W-1:0]              mix_length,
  output logic                          mix_busy,
  output logic                          mix_done,
  output logic                          mix_read,
  output logic [ADDR_W-1:0]             mix_addr,
  input  logic [31:0]                   mix_readdata,
  output logic                          mix_write,
  output logic [31:0]                   mix_writedata,
  input  logic                          mix_sdram_finished
);
  localparam int ACC_W = 16 + GAIN_W + $clog2(NUM_SRC) + 1;
  localparam int SRC_W = $clog2(NUM_SRC + 1);
  localparam int PRD_W = 17 + GAIN_W;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);

  typedef enum logic [2:0] {IDLE, READ, WRITE, NEXT, DONE} state_t;

  state_t                        state_q, state_d;
  logic [LEN_W-1:0]              k_q, k_d, len_q, len_d;
  logic [(NUM_SRC+1)*ADDR_W-1:0] sel_q, sel_d;
  logic [NUM_SRC-1:0]            en_q, en_d;
  logic [NUM_SRC*GAIN_W-1:0]     gain_q, gain_d;
  logic [SRC_W-1:0]              src_q, src_d, src_nxt;
  logic signed [ACC_W-1:0]       acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [GAIN_W-1:0]             cur_gain;
  logic [ADDR_W-1:0]             cur_sel;
  logic signed [PRD_W-1:0]       prod_l, prod_r;

  // Source numbers are 1-based; 0 means "no enabled source above 'after'".
  function automatic logic [SRC_W-1:0] lowest_above(input logic [NUM_SRC-1:0] en, input int after);
    logic [SRC_W-1:0] r;
    r = '0;
    for (int i = NUM_SRC; i >= 1; i--)
      if (i > after && en[i-1]) r = SRC_W'(i);
    return r;
  endfunction

  function automatic logic [15:0] sat(input logic signed [ACC_W-1:0] a);
    return a > SAT_HI ? 16'h7fff : a < SAT_LO ? 16'h8000 : a[15:0];
  endfunction

  always_comb begin
    cur_gain = '0;
    cur_sel  = '0;
    for (int i = 1; i <= NUM_SRC; i++)
      if (src_q == SRC_W'(i)) begin
        cur_gain = gain_q[(i-1)*GAIN_W +: GAIN_W];
        cur_sel  = sel_q[i*ADDR_W +: ADDR_W];
      end
  end

  // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
  assign prod_l  = PRD_W'($signed(mix_readdata[31:16])) * PRD_W'($signed({1'b0, cur_gain}));
  assign prod_r  = PRD_W'($signed(mix_readdata[15:0])) * PRD_W'($signed({1'b0, cur_gain}));
  assign src_nxt = lowest_above(en_q, int'(src_q));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    len_d   = len_q;
    sel_d   = sel_q;
    en_d    = en_q;
    gain_d  = gain_q;
    src_d   = src_q;
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    case (state_q)
      IDLE: if (mix_start) begin
        sel_d   = mix_select;
        en_d    = mix_enable;
        gain_d  = mix_gain;
        len_d   = mix_length;
        k_d     = '0;
        acc_l_d = '0;
        acc_r_d = '0;
        src_d   = lowest_above(mix_enable, 0);
        state_d = mix_length == '0 ? DONE : |mix_enable ? READ : WRITE;
      end
      READ: if (mix_sdram_finished) begin
        acc_l_d = acc_l_q + ACC_W'(prod_l >>> (GAIN_W - 1));
        acc_r_d = acc_r_q + ACC_W'(prod_r >>> (GAIN_W - 1));
        src_d   = src_nxt != '0 ? src_nxt : src_q;
        state_d = src_nxt != '0 ? READ : WRITE;
      end
      WRITE: state_d = mix_sdram_finished ? NEXT : WRITE;
      NEXT: begin
        k_d     = k_q + 1'b1;
        acc_l_d = '0;
        acc_r_d = '0;
        src_d   = lowest_above(en_q, 0);
        state_d = k_d == len_q ? DONE : |en_q ? READ : WRITE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      len_q   <= '0;
      sel_q   <= '0;
      en_q    <= '0;
      gain_q  <= '0;
      src_q   <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      len_q   <= len_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      gain_q  <= gain_d;
      src_q   <= src_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
    end

  // Outputs decode straight from state so an async reset clears them at once.
  always_comb begin
    mix_read      = state_q == READ;
    mix_write     = state_q == WRITE;
    mix_busy      = state_q == READ || state_q == WRITE || state_q == NEXT;
    mix_done      = state_q == DONE;
    mix_addr      = mix_read ? cur_sel + ADDR_W'(k_q) :
                    mix_write ? sel_q[ADDR_W-1:0] + ADDR_W'(k_q) : '0;
    mix_writedata = mix_write ? {sat(acc_l_q), sat(acc_r_q)} : '0;
  end
endmodule

// File: tb/tb_mix_core_n.sv
// tb_mix_core_n: directed scoreboard bench; the bench plays the SDRAM arbiter and
// checks every request against queued expected reads and writes.
module tb_mix_core_n;
  localparam int NS = 4;
  localparam int AW = 23;
  localparam int LW = 16;
  localparam int GW = 8;

  logic                   clk = 0;
  logic                   rst_n = 0;
  logic                   mix_start = 0;
  logic [(NS+1)*AW-1:0]   mix_select = '0;
  logic [NS-1:0]          mix_enable = '0;
  logic [NS*GW-1:0]       mix_gain = '0;
  logic [LW-1:0]          mix_length = '0;
  logic                   mix_busy, mix_done, mix_read, mix_write;
  logic [AW-1:0]          mix_addr;
  logic [31:0]            mix_readdata = '0;
  logic [31:0]            mix_writedata;
  logic                   mix_sdram_finished = 0;

  int checks = 0;
  int errors = 0;
  logic [31:0]    mem [int];
  logic [AW-1:0]  exp_rd [$];
  logic [AW+31:0] exp_wr [$];

  mix_core_n #(.NUM_SRC(NS), .ADDR_W(AW), .LEN_W(LW), .GAIN_W(GW)) dut (
    .i_clk(clk), .i_rst(rst_n), .mix_start(mix_start), .mix_select(mix_select),
    .mix_enable(mix_enable), .mix_gain(mix_gain), .mix_length(mix_length),
    .mix_busy(mix_busy), .mix_done(mix_done), .mix_read(mix_read), .mix_addr(mix_addr),
    .mix_readdata(mix_readdata), .mix_write(mix_write), .mix_writedata(mix_writedata),
    .mix_sdram_finished(mix_sdram_finished)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic setup(input logic [NS-1:0] en);
    mix_select = '0;
    mix_gain   = '0;
    mix_enable = en;
    mem.delete();
    exp_rd.delete();
    exp_wr.delete();
  endtask

  task automatic set_sel(input int s, input logic [AW-1:0] a);
    mix_select[s*AW +: AW] = a;
  endtask

  task automatic set_gain(input int s, input logic [GW-1:0] g);
    mix_gain[(s-1)*GW +: GW] = g;
  endtask

  task automatic exp_w(input logic [AW-1:0] a, input logic [31:0] d);
    exp_wr.push_back({a, d});
  endtask

  // Starts one operation and serves its SDRAM requests with 'lat' extra wait cycles.
  task automatic go(input int len, input int lat, input bit spur, input bit stop_wr, input bit exp_busy);
    int wt = 0;
    bit done = 0;
    bit sp = spur;
    logic [AW-1:0] a0 = '0;
    logic [AW-1:0] er;
    logic [AW+31:0] ew;
    mix_length = LW'(len);
    mix_start = 1;
    @(negedge clk);
    mix_start = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      mix_sdram_finished = 0;
      if (c == 0) chk("busy_after_start", mix_busy, exp_busy);
      chk("rd_wr_exclusive", mix_read & mix_write, 0);
      if (mix_done) begin
        done = 1;
        chk("busy_in_done", mix_busy, 0);
        if (len == 0) chk("len0_done_latency", c, 0);
      end else if (mix_read || mix_write) begin
        if (stop_wr && mix_write) return;
        if (wt == 0) a0 = mix_addr;
        else chk("addr_stable", mix_addr, a0);
        wt++;
        if (wt > lat) begin
          wt = 0;
          mix_sdram_finished = 1;
          if (mix_read) begin
            er = exp_rd.size() > 0 ? exp_rd.pop_front() : 'x;
            chk("rd_addr", mix_addr, er);
            mix_readdata = mem.exists(int'(mix_addr)) ? mem[int'(mix_addr)] : 32'h0;
          end else begin
            ew = exp_wr.size() > 0 ? exp_wr.pop_front() : 'x;
            chk("wr_addr", mix_addr, ew[AW+31:32]);
            chk("wr_data", mix_writedata, ew[31:0]);
          end
        end
      end else if (sp && mix_busy) begin
        sp = 0;
        mix_sdram_finished = 1;
      end
      if (!done) @(negedge clk);
    end
    mix_sdram_finished = 0;
    chk("done_seen", done, 1);
    if (done) begin
      @(negedge clk);
      chk("done_one_cycle", mix_done, 0);
      chk("idle_not_busy", mix_busy, 0);
    end
    chk("reads_left", exp_rd.size(), 0);
    chk("writes_left", exp_wr.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_read", mix_read, 0);
    chk("rst_write", mix_write, 0);
    chk("rst_busy", mix_busy, 0);
    chk("rst_done", mix_done, 0);
    chk("rst_addr", mix_addr, 0);
    chk("rst_wdata", mix_writedata, 0);
    rst_n = 1;
    @(negedge clk);

    // Unity mix of two sources
    setup(4'b0011);
    set_sel(0, 23'h100); set_sel(1, 23'h1000); set_sel(2, 23'h2000);
    set_gain(1, 8'd128); set_gain(2, 8'd128);
    mem[32'h1000] = 32'h1000_F000; mem[32'h2000] = 32'h0100_0200;
    exp_rd.push_back(23'h1000); exp_rd.push_back(23'h2000);
    exp_w(23'h100, 32'h1100_F200);
    go(1, 1, 0, 0, 1);

    // Saturation on both channels, three words, spurious finished in NEXT
    setup(4'b0011);
    set_sel(0, 23'h500); set_sel(1, 23'h3000); set_sel(2, 23'h4000);
    set_gain(1, 8'd128); set_gain(2, 8'd128);
    for (int k = 0; k < 3; k++) begin
      mem[32'h3000 + k] = 32'h7000_9000;
      mem[32'h4000 + k] = 32'h7000_9000;
      exp_rd.push_back(AW'(32'h3000 + k));
      exp_rd.push_back(AW'(32'h4000 + k));
      exp_w(AW'(32'h500 + k), 32'h7FFF_8000);
    end
    go(3, 0, 1, 0, 1);

    // Half gain on source 3 only
    setup(4'b0100);
    set_sel(0, 23'h600); set_sel(1, 23'h5000); set_sel(2, 23'h5100);
    set_sel(3, 23'h6000); set_sel(4, 23'h5300);
    set_gain(1, 8'd128); set_gain(2, 8'd128); set_gain(3, 8'd64); set_gain(4, 8'd128);
    mem[32'h6000] = 32'h0800_FF00;
    exp_rd.push_back(23'h6000);
    exp_w(23'h600, 32'h0400_FF80);
    go(1, 2, 0, 0, 1);

    // Zero length: straight to done, no SDRAM access
    setup(4'b1111);
    set_sel(1, 23'h10);
    go(0, 0, 0, 0, 0);

    // No source enabled: silence written
    setup(4'b0000);
    set_sel(0, 23'h700); set_sel(1, 23'h7000);
    exp_w(23'h700, 32'h0); exp_w(23'h701, 32'h0);
    go(2, 1, 0, 0, 1);

    // Address wrap with slow SDRAM and a spurious finished
    setup(4'b0001);
    set_sel(0, 23'h800); set_sel(1, 23'h7FFFFF); set_gain(1, 8'd128);
    mem[32'h7FFFFF] = 32'h0010_0020; mem[32'h0] = 32'hFFF0_FFE0;
    exp_rd.push_back(23'h7FFFFF); exp_rd.push_back(23'h000000);
    exp_w(23'h800, 32'h0010_0020); exp_w(23'h801, 32'hFFF0_FFE0);
    go(2, 5, 1, 0, 1);

    // Reset while a write is pending, then a fresh run from k=0
    setup(4'b0001);
    set_sel(0, 23'h900); set_sel(1, 23'h8000); set_gain(1, 8'd128);
    mem[32'h8000] = 32'h1234_0567; mem[32'h8001] = 32'h1111_2222;
    exp_rd.push_back(23'h8000);
    go(3, 3, 0, 1, 1);
    chk("pre_rst_write", mix_write, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_write", mix_write, 0);
    chk("async_rst_read", mix_read, 0);
    chk("async_rst_busy", mix_busy, 0);
    chk("async_rst_done", mix_done, 0);
    @(negedge clk);
    rst_n = 1;
    mix_sdram_finished = 0;
    exp_rd.delete();
    exp_wr.delete();
    exp_rd.push_back(23'h8000); exp_rd.push_back(23'h8001);
    exp_w(23'h900, 32'h1234_0567); exp_w(23'h901, 32'h1111_2222);
    @(negedge clk);
    go(2, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
